aes_tl_stream_host: RTL and testbench

- TL-UL host that drives the aes peripheral's register interface from a 128-bit block stream.
- Connects directly to aes tl_i/tl_o and sits upstream of it.
- Accepts key, config and one data block; programs CTRL/KEY/DATA_IN; polls STATUS; reads DATA_OUT; presents the result block downstream.
- Issues single-beat 32-bit transactions, at most one outstanding.

---
 rtl/aes_tl_stream_host.sv | 236 +++++++++++++++++++++++
 tb/tb_aes_tl_stream_host.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/aes_tl_stream_host.sv
// rtl/aes_tl_stream_host.sv - TL-UL host that runs one aes block per stream request.
// Optional STATUS poll timeout: AES_TL_STREAM_HOST_POLL_TIMEOUT_EN.
module aes_tl_stream_host #(
    parameter logic [7:0]  SourceId    = 8'h00,
    parameter logic [31:0] BaseAddr    = 32'h0,
    parameter int unsigned PollTimeout = 1024
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    output logic [101:0]   tl_o,
    input  logic [67:0]    tl_i,
    input  logic           in_valid_i,
    output logic           in_ready_o,
    input  logic [127:0]   in_data_i,
    input  logic [255:0]   in_key_i,
    input  logic           in_key_load_i,
    input  logic           in_mode_i,
    input  logic [2:0]     in_key_len_i,
    output logic           out_valid_o,
    input  logic           out_ready_i,
    output logic [127:0]   out_data_o,
    output logic           busy_o,
    output logic           err_o
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_CFG, ST_KEY, ST_DIN, ST_POLL, ST_DOUT, ST_OUT, ST_ERR
    } state_e;

    state_e         state_q, state_d;
    logic [2:0]     cnt_q, cnt_d;
    logic           a_valid_q, a_valid_d;
    logic           pend_q, pend_d;
    logic [255:0]   key_q, key_d;
    logic [127:0]   data_q, data_d;
    logic           mode_q, mode_d;
    logic [2:0]     key_len_q, key_len_d;
    logic           key_load_q, key_load_d;
    logic [127:0]   out_data_q, out_data_d;

    logic           d_valid, d_sink, d_error, a_ready;
    logic [2:0]     d_opcode, d_param;
    logic [1:0]     d_size;
    logic [7:0]     d_source;
    logic [31:0]    d_data;
    logic [15:0]    d_user;

    assign {d_valid, d_opcode, d_param, d_size, d_source, d_sink,
            d_data, d_user, d_error, a_ready} = tl_i;

    logic unused_tl;
    assign unused_tl = ^{d_param, d_size, d_sink, d_user};

`ifdef AES_TL_STREAM_HOST_POLL_TIMEOUT_EN
    logic [15:0] poll_cnt_q, poll_cnt_d;
`else
    logic [31:0] unused_poll_timeout;
    assign unused_poll_timeout = 32'(PollTimeout);
`endif

    logic        is_read;
    logic [2:0]  a_opcode;
    logic [31:0] a_offset, a_address, a_data;
    logic        rsp_ok;

    assign is_read  = (state_q == ST_POLL) || (state_q == ST_DOUT);
    assign a_opcode = is_read ? 3'd4 : 3'd0;
    assign rsp_ok   = !d_error && (d_source == SourceId) &&
                      (d_opcode == (is_read ? 3'd1 : 3'd0));

    always_comb begin
        a_offset = 32'h0;
        a_data   = 32'h0;
        case (state_q)
            ST_CFG:  begin
                a_offset = 32'h40;
                a_data   = {26'b0, 1'b0, 1'b0, key_len_q, mode_q};
            end
            ST_KEY:  begin
                a_offset = {27'b0, cnt_q, 2'b00};
                a_data   = key_q[cnt_q*32 +: 32];
            end
            ST_DIN:  begin
                a_offset = 32'h20 + {27'b0, cnt_q, 2'b00};
                a_data   = data_q[cnt_q[1:0]*32 +: 32];
            end
            ST_POLL: a_offset = 32'h48;
            ST_DOUT: a_offset = 32'h30 + {27'b0, cnt_q, 2'b00};
            default: a_offset = 32'h0;
        endcase
    end

    assign a_address = BaseAddr + a_offset;
    assign tl_o = {a_valid_q, a_opcode, 3'b0, 2'd2, SourceId, a_address,
                   4'hF, a_data, 16'b0, 1'b1};

    assign in_ready_o  = rst_ni && (state_q == ST_IDLE);
    assign out_valid_o = (state_q == ST_OUT);
    assign out_data_o  = out_data_q;
    assign busy_o      = (state_q != ST_IDLE);
    assign err_o       = (state_q == ST_ERR);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        a_valid_d  = a_valid_q;
        pend_d     = pend_q;
        key_d      = key_q;
        data_d     = data_q;
        mode_d     = mode_q;
        key_len_d  = key_len_q;
        key_load_d = key_load_q;
        out_data_d = out_data_q;
`ifdef AES_TL_STREAM_HOST_POLL_TIMEOUT_EN
        poll_cnt_d = poll_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_valid_i && in_ready_o) begin
                    key_d      = in_key_i;
                    data_d     = in_data_i;
                    mode_d     = in_mode_i;
                    key_len_d  = in_key_len_i;
                    key_load_d = in_key_load_i;
                    state_d    = ST_CFG;
                    cnt_d      = 3'd0;
                    a_valid_d  = 1'b0;
                    pend_d     = 1'b0;
                end
            end
            ST_OUT: begin
                if (out_ready_i) state_d = ST_IDLE;
            end
            ST_ERR: begin
                a_valid_d = 1'b0;
                pend_d    = 1'b0;
            end
            default: begin
                // A fresh request goes out only once the previous response has
                // been consumed, which leaves one idle cycle after each d_valid.
                if (a_valid_q && a_ready) begin
                    a_valid_d = 1'b0;
                    pend_d    = 1'b1;
                end else if (!a_valid_q && !pend_q) begin
                    a_valid_d = 1'b1;
                end
                if (d_valid && !pend_q) begin
                    state_d = ST_ERR;
                end else if (d_valid && pend_q) begin
                    pend_d = 1'b0;
                    if (!rsp_ok) begin
                        state_d = ST_ERR;
                    end else begin
                        case (state_q)
                            ST_CFG: begin
                                state_d = key_load_q ? ST_KEY : ST_DIN;
                                cnt_d   = 3'd0;
                            end
                            ST_KEY: begin
                                if (cnt_q == 3'd7) begin
                                    state_d = ST_DIN;
                                    cnt_d   = 3'd0;
                                end else cnt_d = cnt_q + 3'd1;
                            end
                            ST_DIN: begin
                                if (cnt_q == 3'd3) begin
                                    state_d = ST_POLL;
                                    cnt_d   = 3'd0;
`ifdef AES_TL_STREAM_HOST_POLL_TIMEOUT_EN
                                    poll_cnt_d = 16'd0;
`endif
                                end else cnt_d = cnt_q + 3'd1;
                            end
                            ST_POLL: begin
                                if (d_data[2]) begin
                                    state_d = ST_DOUT;
                                    cnt_d   = 3'd0;
                                end
`ifdef AES_TL_STREAM_HOST_POLL_TIMEOUT_EN
                                else if (({16'b0, poll_cnt_q} + 32'd1) >= 32'(PollTimeout)) begin
                                    state_d = ST_ERR;
                                end else begin
                                    poll_cnt_d = poll_cnt_q + 16'd1;
                                end
`endif
                            end
                            ST_DOUT: begin
                                out_data_d[cnt_q[1:0]*32 +: 32] = d_data;
                                if (cnt_q == 3'd3) state_d = ST_OUT;
                                else cnt_d = cnt_q + 3'd1;
                            end
                            default: state_d = ST_ERR;
                        endcase
                    end
                end
                if (state_d == ST_ERR) begin
                    a_valid_d = 1'b0;
                    pend_d    = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 3'd0;
            a_valid_q  <= 1'b0;
            pend_q     <= 1'b0;
            key_q      <= '0;
            data_q     <= '0;
            mode_q     <= 1'b0;
            key_len_q  <= 3'd0;
            key_load_q <= 1'b0;
            out_data_q <= '0;
`ifdef AES_TL_STREAM_HOST_POLL_TIMEOUT_EN
            poll_cnt_q <= 16'd0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            a_valid_q  <= a_valid_d;
            pend_q     <= pend_d;
            key_q      <= key_d;
            data_q     <= data_d;
            mode_q     <= mode_d;
            key_len_q  <= key_len_d;
            key_load_q <= key_load_d;
            out_data_q <= out_data_d;
`ifdef AES_TL_STREAM_HOST_POLL_TIMEOUT_EN
            poll_cnt_q <= poll_cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_aes_tl_stream_host.sv
// tb/tb_aes_tl_stream_host.sv - directed bench for aes_tl_stream_host with a TL-UL aes register model.
module tb_aes_tl_stream_host;

    logic           clk = 1'b0;
    logic           rst_ni;
    logic [101:0]   tl_o;
    logic [67:0]    tl_i;
    logic           in_valid, in_ready, in_key_load, in_mode, out_valid, out_ready, busy, err;
    logic [127:0]   in_data, out_data;
    logic [255:0]   in_key;
    logic [2:0]     in_key_len;

    logic           d_valid, d_error, a_ready;
    logic [2:0]     d_opcode;
    logic [31:0]    d_data;

    always #5 clk = ~clk;

    assign tl_i = {d_valid, d_opcode, 3'b0, 2'd2, 8'h00, 1'b0, d_data, 16'b0, d_error, a_ready};

    wire        a_valid   = tl_o[101];
    wire [2:0]  a_opcode  = tl_o[100:98];
    wire [31:0] a_address = tl_o[84:53];
    wire [31:0] a_data    = tl_o[48:17];

    aes_tl_stream_host #(.SourceId(8'h00), .BaseAddr(32'h0), .PollTimeout(4)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .tl_o(tl_o), .tl_i(tl_i),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
        .in_key_i(in_key), .in_key_load_i(in_key_load), .in_mode_i(in_mode),
        .in_key_len_i(in_key_len), .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_data_o(out_data), .busy_o(busy), .err_o(err)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] addr_log[$];
    logic [31:0] data_log[$];
    logic [31:0] stall_addr = 32'h0C, err_addr = 32'hFFFF_FFFF, held_addr, held_data;
    int stall_left = 3, stall_cycles = 0, stall_unstable = 0, stat_bad = 0;
    int status_after = 2, poll_n = 0, err_cyc = -100;
    logic pend_resp = 1'b0, r_op, r_err;
    logic [31:0] r_data;
    logic [31:0] dout_words [4] = '{32'hd8e0c469, 32'h30047b6a, 32'h80b7cdd8, 32'h5ac5b470};
    localparam logic [127:0] FIPS_CT = 128'h5ac5b470_80b7cdd8_30047b6a_d8e0c469;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // aes register model: one-cycle ack, optional stall and error injection
    initial begin
        d_valid = 0; d_error = 0; d_opcode = 0; d_data = 0; a_ready = 1;
        forever begin
            @(negedge clk);
            d_valid = 0; d_error = 0;
            if (pend_resp) begin
                d_valid = 1; d_opcode = {2'b0, r_op}; d_data = r_data; d_error = r_err;
                pend_resp = 0;
                if (r_err) err_cyc = cyc;
            end
            a_ready = 1;
            if (a_valid && a_address == stall_addr && stall_left > 0) begin
                a_ready = 0;
                if (stall_cycles == 0) begin
                    held_addr = a_address; held_data = a_data;
                end else if (a_address != held_addr || a_data != held_data) stall_unstable++;
                stall_left--; stall_cycles++;
            end
            if (a_valid && a_ready) begin
                if (stall_cycles > 0 && a_address == stall_addr &&
                    (a_address != held_addr || a_data != held_data)) stall_unstable++;
                if (tl_o[97:93] != 5'b000_10 || tl_o[92:85] != 8'h00 || tl_o[52:49] != 4'hF ||
                    tl_o[16:0] != 17'h1 || (a_opcode == 3'd4 && a_data != 0)) stat_bad++;
                addr_log.push_back(a_address);
                data_log.push_back(a_data);
                pend_resp = 1;
                r_op = (a_opcode == 3'd4);
                r_err = (a_address == err_addr);
                r_data = 32'h0;
                if (a_address == 32'h48) begin
                    poll_n++;
                    r_data = (poll_n > status_after) ? 32'h4 : 32'h0;
                end else if (a_address >= 32'h30 && a_address <= 32'h3C)
                    r_data = dout_words[(a_address - 32'h30) >> 2];
            end
        end
    end

    task automatic start_block(input logic kl, input logic md, input logic [2:0] klen,
                               input logic [255:0] key, input logic [127:0] data);
        @(negedge clk);
        in_key_load = kl; in_mode = md; in_key_len = klen; in_key = key; in_data = data;
        in_valid = 1;
        @(negedge clk);
        in_valid = 0;
    endtask

    initial begin
        int a_cnt;
        logic [31:0] exp_addr;
        rst_ni = 0; in_valid = 0; out_ready = 0; in_key_load = 0; in_mode = 0;
        in_key_len = 3'b001; in_key = '0; in_data = '0;
        repeat (2) @(negedge clk);
        check("rst_a_valid", a_valid, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_err", err, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 0);
        rst_ni = 1;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1);

        // FIPS-197 block with key load and a 3-cycle stall on KEY3
        start_block(1'b1, 1'b0, 3'b001,
                    {128'h0, 32'h0f0e0d0c, 32'h0b0a0908, 32'h07060504, 32'h03020100},
                    {32'hffeeddcc, 32'hbbaa9988, 32'h77665544, 32'h33221100});
        check("b1_busy", busy, 1);
        check("b1_in_ready", in_ready, 0);
        for (int i = 0; i < 400 && !out_valid; i++) @(negedge clk);
        check("b1_out_valid", out_valid, 1);
        check("b1_n_req", addr_log.size(), 20);
        for (int i = 0; i < 20 && i < addr_log.size(); i++) begin
            if (i == 0) exp_addr = 32'h40;
            else if (i <= 8) exp_addr = 32'(i - 1) * 4;
            else if (i <= 12) exp_addr = 32'h20 + 32'(i - 9) * 4;
            else if (i <= 15) exp_addr = 32'h48;
            else exp_addr = 32'h30 + 32'(i - 16) * 4;
            check($sformatf("b1_addr%0d", i), addr_log[i], exp_addr);
        end
        check("b1_ctrl", data_log[0], 32'h2);
        check("b1_key0", data_log[1], 32'h03020100);
        check("b1_key3", data_log[4], 32'h0f0e0d0c);
        check("b1_din0", data_log[9], 32'h33221100);
        check("b1_din3", data_log[12], 32'hffeeddcc);
        check("b1_stall_cycles", stall_cycles, 3);
        check("b1_stall_stable", stall_unstable, 0);
        check("b1_out_data", out_data, FIPS_CT);
        repeat (5) @(negedge clk);
        check("b1_hold_valid", out_valid, 1);
        check("b1_hold_data", out_data, FIPS_CT);
        out_ready = 1;
        @(negedge clk);
        out_ready = 0;
        check("b1_done_valid", out_valid, 0);
        check("b1_done_in_ready", in_ready, 1);

        // second block reuses the key: CTRL goes straight to DATA_IN0
        addr_log.delete(); data_log.delete(); poll_n = 0; status_after = 0;
        start_block(1'b0, 1'b1, 3'b100, '1, 128'h0123);
        for (int i = 0; i < 400 && !out_valid; i++) @(negedge clk);
        check("b2_out_valid", out_valid, 1);
        check("b2_n_req", addr_log.size(), 10);
        check("b2_addr0", addr_log[0], 32'h40);
        check("b2_addr1", addr_log[1], 32'h20);
        check("b2_ctrl", data_log[0], 32'h9);
        check("b2_din0", data_log[1], 32'h0123);
        check("b2_static", stat_bad, 0);
        out_ready = 1;
        @(negedge clk);
        out_ready = 0;
        check("b2_idle", busy, 0);

        // error response on the DATA_IN2 write
        addr_log.delete(); data_log.delete(); err_addr = 32'h28;
        start_block(1'b0, 1'b0, 3'b001, '0, 128'h5);
        for (int i = 0; i < 200 && !err; i++) @(negedge clk);
        check("e_err", err, 1);
        check("e_latency", cyc - err_cyc, 1);
        in_valid = 1;
        a_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (a_valid) a_cnt++;
        end
        in_valid = 0;
        check("e_no_a_valid", a_cnt, 0);
        check("e_in_ready", in_ready, 0);
        check("e_n_req", addr_log.size(), 4);
        check("e_sticky", err, 1);

        // STATUS never reports OUTPUT_VALID
        rst_ni = 0;
        repeat (2) @(negedge clk);
        rst_ni = 1;
        addr_log.delete(); data_log.delete(); err_addr = 32'hFFFF_FFFF;
        poll_n = 0; status_after = 1000;
        check("t_err_cleared", err, 0);
        start_block(1'b0, 1'b0, 3'b001, '0, 128'h7);
`ifdef AES_TL_STREAM_HOST_POLL_TIMEOUT_EN
        for (int i = 0; i < 300 && !err; i++) @(negedge clk);
        check("t_err", err, 1);
        check("t_polls", poll_n, 4);
        a_cnt = 0;
        foreach (addr_log[i]) if (addr_log[i] == 32'h48) a_cnt++;
        check("t_status_reads", a_cnt, 4);
`else
        repeat (150) @(negedge clk);
        check("t_no_err", err, 0);
        check("t_busy", busy, 1);
        check("t_still_polling", poll_n > 4, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
